trigger_capture_buffer: RTL and testbench

//  Captures a burst of ADC sample bytes after an armed trigger edge and streams them to the PC.
//  Arm/abort commands arrive on the RxD command byte bus. Output drives the FIFO channel of TxDWrapper
//  (FIFODataOut / FIFORequestToSend / FIFODataReceived), downstream of ADC capture.

---
 rtl/trigger_capture_buffer_pkg.sv | 27 ++
 rtl/trigger_capture_buffer_capture_ram.sv | 26 ++
 rtl/trigger_capture_buffer.sv | 170 +++++++++++++++++
 tb/tb_trigger_capture_buffer.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trigger_capture_buffer_pkg.sv
// Shared constants, state encoding and header helper for the trigger capture buffer.
// Latency: none (declarations only).
// Backpressure: not applicable.
package trigger_capture_buffer_pkg;

   localparam logic [7:0] CMD_ARM   = 8'h54;  // 'T'
   localparam logic [7:0] CMD_ABORT = 8'h58;  // 'X'
   localparam logic [7:0] HDR_SYNC  = 8'hA5;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ARMED   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_HEADER  = 3'd3,
      ST_DUMP    = 3'd4
   } state_t;

   // Header byte sequence: sync, length high byte, length low byte.
   function automatic logic [7:0] header_byte(input logic [1:0] idx, input logic [15:0] len);
      case (idx)
         2'd0:    return HDR_SYNC;
         2'd1:    return len[15:8];
         default: return len[7:0];
      endcase
   endfunction

endpackage

// File: rtl/trigger_capture_buffer_capture_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// Latency: read data valid one cycle after the read address is presented.
// Backpressure: none; writes and reads are accepted every cycle. Array is not reset.
module capture_ram #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 8
) (
   input  logic              i_clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_waddr,
   input  logic [DATA_W-1:0] i_wdata,
   input  logic [ADDR_W-1:0] i_raddr,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [0:(1<<ADDR_W)-1];

   // Write port and registered read port; no reset so the array maps to block RAM.
   always_ff @(posedge i_clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
      o_rdata <= r_mem[i_raddr];
   end

endmodule

// File: rtl/trigger_capture_buffer.sv
// Arms on 'T', captures 2**DEPTH_LOG2 samples after a trigger edge, then streams them to the TxD FIFO channel.
// Latency: RequestToSend rises one cycle after the read address is presented; one idle cycle between bytes.
// Backpressure: each byte is held until DataReceived; 'X' aborts anywhere. CAPTURE_HEADER_EN adds a 3-byte header.
module trigger_capture_buffer
   import trigger_capture_buffer_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [7:0]            i_cmd,
   input  logic                  i_cmd_valid,
   input  logic [DATA_WIDTH-1:0] i_sample_in,
   input  logic                  i_sample_valid,
   input  logic                  i_trigger,
   output logic [DATA_WIDTH-1:0] o_data_out,
   output logic                  o_request_to_send,
   input  logic                  i_data_received,
   output logic                  o_armed,
   output logic                  o_busy
);

   localparam int            CW  = DEPTH_LOG2 + 1;
   localparam logic [CW-1:0] LEN = CW'(1) << DEPTH_LOG2;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CW-1:0]           r_wr_ptr;
   logic [CW-1:0]           w_wr_ptr_nxt;
   logic [CW-1:0]           r_rd_ptr;
   logic [CW-1:0]           w_rd_ptr_nxt;
   logic                    r_rts;
   logic                    w_rts_nxt;
   logic                    r_trig_q;
   logic                    w_we;
   logic                    w_abort;
   logic                    w_arm;
   logic                    w_edge;
   logic [CW-1:0]           w_wr_inc;
   logic [CW-1:0]           w_rd_inc;
   logic [DATA_WIDTH-1:0]   w_rd_dat;
   state_t                  w_post_capture;

   assign w_abort  = i_cmd_valid && (i_cmd == CMD_ABORT);
   assign w_arm    = i_cmd_valid && (i_cmd == CMD_ARM);
   assign w_edge   = i_trigger && !r_trig_q;
   assign w_wr_inc = r_wr_ptr + CW'(1);
   assign w_rd_inc = r_rd_ptr + CW'(1);

`ifdef CAPTURE_HEADER_EN
   localparam logic [15:0]   LEN16     = 16'(LEN);
   localparam logic [CW-1:0] HDR_BYTES = CW'(3);
   assign w_post_capture = ST_HEADER;
`else
   assign w_post_capture = ST_DUMP;
`endif

   capture_ram #(
      .ADDR_W (DEPTH_LOG2),
      .DATA_W (DATA_WIDTH)
   ) u_ram (
      .i_clk   (i_clk),
      .i_we    (w_we),
      .i_waddr (r_wr_ptr[DEPTH_LOG2-1:0]),
      .i_wdata (i_sample_in),
      .i_raddr (r_rd_ptr[DEPTH_LOG2-1:0]),
      .o_rdata (w_rd_dat)
   );

   // Next-state logic: abort wins over everything, then per-state capture/handshake rules.
   always_comb begin
      w_state_nxt  = r_state;
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      w_rts_nxt    = r_rts;
      w_we         = 1'b0;
      if (w_abort) begin
         w_state_nxt  = ST_IDLE;
         w_wr_ptr_nxt = '0;
         w_rd_ptr_nxt = '0;
         w_rts_nxt    = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_arm) w_state_nxt = ST_ARMED;
            end
            ST_ARMED: begin
               if (w_edge) begin
                  w_state_nxt = ST_CAPTURE;
                  w_we        = i_sample_valid;
               end
            end
            ST_CAPTURE: begin
               w_we = i_sample_valid;
            end
`ifdef CAPTURE_HEADER_EN
            ST_HEADER: begin
               if (!r_rts) begin
                  w_rts_nxt = 1'b1;
               end else if (i_data_received) begin
                  w_rts_nxt = 1'b0;
                  if (w_rd_inc == HDR_BYTES) begin
                     w_state_nxt  = ST_DUMP;
                     w_rd_ptr_nxt = '0;
                  end else begin
                     w_rd_ptr_nxt = w_rd_inc;
                  end
               end
            end
`endif
            ST_DUMP: begin
               // RAM output for rd_ptr is ready the cycle after rts is low, so raise it then.
               if (!r_rts) begin
                  w_rts_nxt = 1'b1;
               end else if (i_data_received) begin
                  w_rts_nxt = 1'b0;
                  if (w_rd_inc == LEN) begin
                     w_state_nxt  = ST_IDLE;
                     w_rd_ptr_nxt = '0;
                  end else begin
                     w_rd_ptr_nxt = w_rd_inc;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
         // Shared write bookkeeping; the last sample closes the capture window.
         if (w_we) begin
            w_wr_ptr_nxt = w_wr_inc;
            if (w_wr_inc == LEN) begin
               w_state_nxt  = w_post_capture;
               w_wr_ptr_nxt = '0;
            end
         end
      end
   end

   // State, pointer and trigger-history registers with synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state  <= ST_IDLE;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_rts    <= 1'b0;
         r_trig_q <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_rts    <= w_rts_nxt;
         r_trig_q <= i_trigger;
      end
   end

`ifdef CAPTURE_HEADER_EN
   assign o_data_out = !r_rts ? '0 :
                       (r_state == ST_HEADER) ? DATA_WIDTH'(header_byte(r_rd_ptr[1:0], LEN16)) :
                       w_rd_dat;
`else
   assign o_data_out = r_rts ? w_rd_dat : '0;
`endif

   assign o_request_to_send = r_rts;
   assign o_armed           = (r_state == ST_ARMED);
   assign o_busy            = (r_state == ST_CAPTURE) || (r_state == ST_HEADER) || (r_state == ST_DUMP);

endmodule

// File: tb/tb_trigger_capture_buffer.sv
// Directed/randomized bench: a byte-queue model of the expected stream checked against the DUT.
// Latency: bench steps on the falling edge; outputs are sampled there, inputs change there.
// Backpressure: DataReceived is issued after a random or fixed hold once RequestToSend is seen.
module tb_trigger_capture_buffer;

   localparam int DL2 = 3;
   localparam int LEN = 1 << DL2;

   logic       i_clk = 1'b0;
   logic       i_reset;
   logic [7:0] i_cmd;
   logic       i_cmd_valid;
   logic [7:0] i_sample_in;
   logic       i_sample_valid;
   logic       i_trigger;
   logic [7:0] o_data_out;
   logic       o_request_to_send;
   logic       i_data_received;
   logic       o_armed;
   logic       o_busy;

   int         checks = 0;
   int         passes = 0;
   logic [7:0] exp_q[$];

   always #5 i_clk = ~i_clk;

   trigger_capture_buffer #(
      .DEPTH_LOG2 (DL2),
      .DATA_WIDTH (8)
   ) dut (
      .i_clk             (i_clk),
      .i_reset           (i_reset),
      .i_cmd             (i_cmd),
      .i_cmd_valid       (i_cmd_valid),
      .i_sample_in       (i_sample_in),
      .i_sample_valid    (i_sample_valid),
      .i_trigger         (i_trigger),
      .o_data_out        (o_data_out),
      .o_request_to_send (o_request_to_send),
      .i_data_received   (i_data_received),
      .o_armed           (o_armed),
      .o_busy            (o_busy)
   );

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(negedge i_clk);
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic send_cmd(input logic [7:0] b);
      i_cmd       = b;
      i_cmd_valid = 1'b1;
      step();
      i_cmd_valid = 1'b0;
      i_cmd       = 8'($urandom);
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_rts"}, o_request_to_send, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_armed"}, o_armed, 0);
   endtask

   // Arm, then offer samples while armed with no trigger edge: none of them may be stored.
   task automatic arm();
      send_cmd(8'h54);
      check("arm_armed", o_armed, 1);
      check("arm_busy", o_busy, 0);
      i_sample_valid = 1'b1;
      repeat (2) begin
         i_sample_in = 8'($urandom);
         step();
      end
      i_sample_valid = 1'b0;
      check("arm_still_armed", o_armed, 1);
   endtask

   // Model: the stream is the optional header followed by the first LEN valid samples from the edge on.
   task automatic do_capture(input bit fixed, input bit edge_sample, input bit noisy_trig);
      int         n = 0;
      logic [7:0] s;
`ifdef CAPTURE_HEADER_EN
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(LEN >> 8));
      exp_q.push_back(8'(LEN & 255));
`endif
      i_trigger = 1'b1;
      if (edge_sample) begin
         s = fixed ? 8'h10 : 8'($urandom);
         i_sample_in    = s;
         i_sample_valid = 1'b1;
         exp_q.push_back(s);
         n = 1;
      end else begin
         i_sample_valid = 1'b0;
      end
      step();
      check("cap_busy", o_busy, 1);
      check("cap_armed", o_armed, 0);
      while (n < LEN) begin
         i_trigger = noisy_trig ? 1'($urandom_range(0, 1)) : 1'b0;
         if (fixed || $urandom_range(0, 2) != 0) begin
            s = fixed ? 8'(16 + n) : 8'($urandom);
            i_sample_in    = s;
            i_sample_valid = 1'b1;
            exp_q.push_back(s);
            n++;
         end else begin
            i_sample_valid = 1'b0;
            i_sample_in    = 8'($urandom);
         end
         step();
      end
      i_sample_valid = 1'b0;
      i_trigger      = 1'b0;
      check("dump_busy", o_busy, 1);
   endtask

   // Take nbytes from the stream; hold < 0 picks a random 0..3 cycle delay before DataReceived.
   task automatic receive(input int nbytes, input int hold);
      for (int k = 0; k < nbytes; k++) begin
         int         t = 0;
         int         h;
         logic [7:0] e;
         while (o_request_to_send !== 1'b1 && t < 40) begin
            i_data_received = 1'($urandom_range(0, 1));
            step();
            t++;
         end
         i_data_received = 1'b0;
         check("rts_rise", o_request_to_send, 1);
         e = exp_q.pop_front();
         check("byte", o_data_out, e);
         h = (hold < 0) ? $urandom_range(0, 3) : hold;
         repeat (h) begin
            step();
            check("rts_hold", o_request_to_send, 1);
            check("dat_hold", o_data_out, e);
         end
         i_data_received = 1'b1;
         step();
         i_data_received = 1'b0;
         check("rts_drop", o_request_to_send, 0);
         if (k < nbytes - 1) begin
            i_data_received = 1'b1;
            step();
            i_data_received = 1'b0;
            check("gap_one", o_request_to_send, 1);
         end
      end
   endtask

   initial begin
      i_reset         = 1'b1;
      i_cmd           = 8'h00;
      i_cmd_valid     = 1'b0;
      i_sample_in     = 8'h00;
      i_sample_valid  = 1'b0;
      i_trigger       = 1'b0;
      i_data_received = 1'b0;
      step();
      step();
      check("reset_data", o_data_out, 0);
      check_idle("reset");
      i_reset = 1'b0;
      step();

      // Garbage command in IDLE is ignored.
      send_cmd(8'h41);
      check_idle("garbage");

      // Incrementing samples, DataReceived two cycles after each RTS.
      arm();
      do_capture(1'b1, 1'b0, 1'b0);
      receive(exp_q.size(), 2);
      check_idle("run1_done");

      // Sample in the edge cycle is sample 0; extra trigger edges during capture change nothing.
      arm();
      do_capture(1'b1, 1'b1, 1'b1);
      receive(exp_q.size(), -1);
      check_idle("run2_done");

      // Abort after three bytes, then re-arm; arm during readout is ignored.
      arm();
      do_capture(1'b0, 1'b0, 1'b0);
      receive(3, -1);
      send_cmd(8'h58);
      check_idle("abort_dump");
      exp_q.delete();
      repeat (3) step();
      check("abort_quiet_rts", o_request_to_send, 0);
      arm();
      do_capture(1'b0, 1'b0, 1'b1);
      receive(1, -1);
      send_cmd(8'h54);
      check("arm_in_dump_armed", o_armed, 0);
      check("arm_in_dump_busy", o_busy, 1);
      check("arm_in_dump_rts", o_request_to_send, 1);
      receive(exp_q.size(), -1);
      check_idle("run4_done");

      // Reset mid-capture clears outputs; DataReceived with RTS low has no effect.
      arm();
      i_trigger      = 1'b1;
      i_sample_valid = 1'b1;
      repeat (3) begin
         i_sample_in = 8'($urandom);
         step();
      end
      i_reset = 1'b1;
      step();
      i_reset        = 1'b0;
      i_sample_valid = 1'b0;
      i_trigger      = 1'b0;
      check("rst_mid_data", o_data_out, 0);
      check_idle("rst_mid");
      i_data_received = 1'b1;
      step();
      i_data_received = 1'b0;
      check_idle("dr_idle");
      arm();
      do_capture(1'b0, 1'b1, 1'b0);
      receive(exp_q.size(), -1);
      check_idle("run5_done");

      // Abort beats a trigger edge in the same cycle.
      arm();
      i_trigger = 1'b1;
      send_cmd(8'h58);
      i_trigger = 1'b0;
      check_idle("abort_vs_edge");

      // Abort beats the last-sample write.
      arm();
      i_trigger = 1'b1;
      step();
      i_trigger      = 1'b0;
      i_sample_valid = 1'b1;
      repeat (LEN - 1) begin
         i_sample_in = 8'($urandom);
         step();
      end
      send_cmd(8'h58);
      i_sample_valid = 1'b0;
      check_idle("abort_vs_last");
      step();
      check_idle("abort_vs_last_after");

      // Abort beats DataReceived.
      arm();
      do_capture(1'b0, 1'b0, 1'b0);
      receive(2, -1);
      i_data_received = 1'b1;
      send_cmd(8'h58);
      i_data_received = 1'b0;
      check_idle("abort_vs_dr");
      exp_q.delete();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
